// File: rtl/lif_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lif_pkg
//  Description : Shared FSM states, Q16.16 constants and helpers for the LIF array.
//  Revision    : 1.0 - initial release
// ============================================================================
package lif_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAK  = 3'd1,
        ST_INTEG = 3'd2,
        ST_FIRE  = 3'd3,
        ST_DONE  = 3'd4
    } lif_state_e;

    localparam int          c_frac_default  = 16;
    localparam logic [31:0] c_fxp_one       = 32'd1 << c_frac_default;
    localparam logic [31:0] c_vth_default   = 32'h0000_FC93;
    localparam logic [31:0] c_vrest_default = 32'h0000_0000;

    // Index width for a count of n items, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lif_update_dp.sv
`default_nettype none
// ============================================================================
//  Module      : lif_update_dp
//  Description : Combinational leak/integrate/fire arithmetic for one neuron.
//  Revision    : 1.0 - initial release
// ============================================================================
module lif_update_dp #(
    parameter int             DW            = 32,
    parameter int             LEAK_SHIFT    = 3,
    parameter int             RW            = 2,
    parameter logic [RW-1:0]  REFRAC_RELOAD = 2'd2,
    parameter logic [DW-1:0]  VREST         = '0
) (
    input  logic [DW-1:0] v_i,
    input  logic [DW-1:0] cur_i,
    input  logic [DW:0]   diff_i,
    input  logic [DW-1:0] sum_i,
    input  logic [RW-1:0] refrac_i,
    input  logic [DW-1:0] vth_i,
    output logic [DW:0]   diff_o,
    output logic [DW-1:0] sum_o,
    output logic [DW-1:0] v_next_o,
    output logic          spike_o,
    output logic [RW-1:0] refrac_next_o
);

    logic signed [DW:0] w_shifted;

    always_comb begin
        diff_o        = {cur_i[DW-1], cur_i} - {v_i[DW-1], v_i};
        w_shifted     = $signed(diff_i) >>> LEAK_SHIFT;
        // The sum lies between v and I, so dropping the top bit never wraps.
        sum_o         = v_i + DW'(w_shifted);
        v_next_o      = sum_i;
        spike_o       = 1'b0;
        refrac_next_o = refrac_i;
        if (refrac_i != '0) begin
            v_next_o      = VREST;
            refrac_next_o = refrac_i - 1'b1;
        end else if ($signed(sum_i) >= $signed(vth_i)) begin
            v_next_o      = VREST;
            spike_o       = 1'b1;
            refrac_next_o = REFRAC_RELOAD;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lif_neuron_array.sv
`default_nettype none
// ============================================================================
//  Module      : lif_neuron_array
//  Description : Time-multiplexed LIF neuron array, one shared datapath, step handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module lif_neuron_array
    import lif_pkg::*;
#(
    parameter int            N_NEURONS  = 4,
    parameter int            DW         = 32,
    parameter int            FRAC       = 16,
    parameter int            LEAK_SHIFT = 3,
    parameter logic [DW-1:0] VTH        = c_vth_default,
    parameter logic [DW-1:0] VREST      = c_vrest_default,
    parameter int            REFRAC     = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    step_valid,
    output logic                    step_ready,
    input  logic [N_NEURONS*DW-1:0] i_in,
    output logic                    out_valid,
    output logic [N_NEURONS-1:0]    spike,
    output logic [N_NEURONS*DW-1:0] v_out
);

    localparam int            c_iw   = idx_width(N_NEURONS);
    localparam int            c_rw   = idx_width(REFRAC + 1);
    localparam logic [c_iw-1:0] c_last = c_iw'(N_NEURONS - 1);

    if (FRAC >= DW) begin : g_bad_frac
        $error("FRAC must be smaller than DW");
    end

    lif_state_e r_state_q, w_state_d;

    logic [c_iw-1:0]         r_idx_q;
    logic [N_NEURONS*DW-1:0] r_cur_q;
    logic [DW:0]             r_diff_q;
    logic [DW-1:0]           r_sum_q;
    logic [N_NEURONS-1:0]    r_spike_q;
    logic [DW-1:0]           r_v_q      [N_NEURONS];
    logic [c_rw-1:0]         r_refrac_q [N_NEURONS];
    logic [DW-1:0]           w_cur_lane [N_NEURONS];

    logic [DW:0]     w_diff;
    logic [DW-1:0]   w_sum;
    logic [DW-1:0]   w_v_next;
    logic            w_spike;
    logic [c_rw-1:0] w_refrac_next;

    for (genvar k = 0; k < N_NEURONS; k++) begin : g_lane
        assign w_cur_lane[k]      = r_cur_q[k*DW +: DW];
        assign v_out[k*DW +: DW]  = r_v_q[k];
    end

    assign spike = r_spike_q;

    lif_update_dp #(
        .DW            (DW),
        .LEAK_SHIFT    (LEAK_SHIFT),
        .RW            (c_rw),
        .REFRAC_RELOAD (c_rw'(REFRAC)),
        .VREST         (VREST)
    ) u_dp (
        .v_i           (r_v_q[r_idx_q]),
        .cur_i         (w_cur_lane[r_idx_q]),
        .diff_i        (r_diff_q),
        .sum_i         (r_sum_q),
        .refrac_i      (r_refrac_q[r_idx_q]),
        .vth_i         (VTH),
        .diff_o        (w_diff),
        .sum_o         (w_sum),
        .v_next_o      (w_v_next),
        .spike_o       (w_spike),
        .refrac_next_o (w_refrac_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= ST_IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    always_comb begin
        w_state_d  = r_state_q;
        step_ready = 1'b0;
        out_valid  = 1'b0;
        case (r_state_q)
            ST_IDLE: begin
                step_ready = 1'b1;
                if (step_valid) w_state_d = ST_LEAK;
            end
            ST_LEAK:  w_state_d = ST_INTEG;
            ST_INTEG: w_state_d = ST_FIRE;
            ST_FIRE:  w_state_d = (r_idx_q == c_last) ? ST_DONE : ST_LEAK;
            ST_DONE: begin
                out_valid = 1'b1;
                w_state_d = ST_IDLE;
            end
            default:  w_state_d = ST_IDLE;
        endcase
    end

    // Stage registers; each state commits exactly one datapath result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx_q   <= '0;
            r_cur_q   <= '0;
            r_diff_q  <= '0;
            r_sum_q   <= '0;
            r_spike_q <= '0;
            for (int k = 0; k < N_NEURONS; k++) begin
                r_v_q[k]      <= VREST;
                r_refrac_q[k] <= '0;
            end
        end else begin
            case (r_state_q)
                ST_IDLE: begin
                    if (step_valid) begin
                        r_cur_q   <= i_in;
                        r_idx_q   <= '0;
                        r_spike_q <= '0;
                    end
                end
                ST_LEAK:  r_diff_q <= w_diff;
                ST_INTEG: r_sum_q  <= w_sum;
                ST_FIRE: begin
                    r_v_q[r_idx_q]      <= w_v_next;
                    r_refrac_q[r_idx_q] <= w_refrac_next;
                    r_spike_q[r_idx_q]  <= w_spike;
                    if (r_idx_q != c_last) r_idx_q <= r_idx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lif_neuron_array.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lif_neuron_array
//  Description : Scoreboard bench for lif_neuron_array against an arithmetic LIF model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lif_neuron_array;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam longint c_vth = 64659;   // 0x0000FC93

    typedef struct packed {
        logic [N-1:0]    spk;
        logic [N*DW-1:0] v;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            step_valid;
    logic            step_ready;
    logic [N*DW-1:0] i_in;
    logic            out_valid;
    logic [N-1:0]    spike;
    logic [N*DW-1:0] v_out;

    lif_neuron_array dut (
        .clk        (clk),
        .rst        (rst),
        .step_valid (step_valid),
        .step_ready (step_ready),
        .i_in       (i_in),
        .out_valid  (out_valid),
        .spike      (spike),
        .v_out      (v_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int n_push   = 0;
    int n_pop    = 0;

    exp_t   sb[$];
    longint m_v   [N];
    int     m_ref [N];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic longint floor_div8(input longint d);
        longint q;
        q = d / 8;
        if (d < 0 && (d % 8) != 0) q = q - 1;
        return q;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < N; k++) begin
            m_v[k]   = 0;
            m_ref[k] = 0;
        end
    endfunction

    // Advance every neuron one step and return the resulting spikes/potentials.
    function automatic exp_t model_step(input logic [N*DW-1:0] cur);
        exp_t   e;
        longint cur_k, s;
        for (int k = 0; k < N; k++) begin
            cur_k    = longint'($signed(cur[k*DW +: DW]));
            e.spk[k] = 1'b0;
            if (m_ref[k] > 0) begin
                m_v[k]   = 0;
                m_ref[k] = m_ref[k] - 1;
            end else begin
                s = m_v[k] + floor_div8(cur_k - m_v[k]);
                if (s >= c_vth) begin
                    m_v[k]   = 0;
                    m_ref[k] = 2;
                    e.spk[k] = 1'b1;
                end else begin
                    m_v[k] = s;
                end
            end
            e.v[k*DW +: DW] = m_v[k][DW-1:0];
        end
        return e;
    endfunction

    function automatic int predict_first_spike();
        longint v;
        v = 0;
        for (int n = 1; n < 200; n++) begin
            v = v + floor_div8(65536 - v);
            if (v >= c_vth) return n;
        end
        return -1;
    endfunction

    function automatic logic [N*DW-1:0] rand_cur();
        logic [N*DW-1:0] r;
        int              t;
        for (int k = 0; k < N; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                r[k*DW +: DW] = $urandom;
            end else begin
                t = int'($urandom_range(0, 262143)) - 131072;
                r[k*DW +: DW] = t;
            end
        end
        return r;
    endfunction

    function automatic void flush_sb();
        n_push = n_push - sb.size();
        sb.delete();
    endfunction

    // Monitor: every out_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid) begin
            check("ready_low_in_done", {127'd0, step_ready}, '0);
            if (sb.size() == 0) begin
                check("unexpected_out_valid", {127'd0, out_valid}, '0);
            end else begin
                e = sb.pop_front();
                n_pop++;
                check("sb_spike", {124'd0, spike}, {124'd0, e.spk});
                check("sb_v_out", v_out, e.v);
            end
        end
    end

    task automatic issue_step(input logic [N*DW-1:0] cur);
        int g;
        @(negedge clk);
        i_in       = cur;
        step_valid = 1'b1;
        g = 0;
        while (!step_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        sb.push_back(model_step(cur));
        n_push++;
        @(posedge clk);
        #1;
        step_valid = 1'b0;
        i_in       = rand_cur();
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!out_valid && t < 100);
        if (!out_valid) check("step_timeout", '0, {127'd0, 1'b1});
    endtask

    task automatic run_step(input logic [N*DW-1:0] cur);
        issue_step(cur);
        wait_done();
    endtask

    initial begin
        logic [N*DW-1:0] one0;
        int first_pred, first_seen, after, acc, low, last_acc, guard;

        one0       = '0;
        one0[31:0] = 32'h0001_0000;
        rst        = 1'b1;
        step_valid = 1'b1;
        i_in       = rand_cur();
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_v_out", v_out, '0);
        check("rst_spike", {124'd0, spike}, '0);
        check("rst_out_valid", {127'd0, out_valid}, '0);
        step_valid = 1'b0;
        rst        = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {127'd0, step_ready}, {127'd0, 1'b1});

        // Integration up to the first spike, then through the refractory steps.
        first_pred = predict_first_spike();
        first_seen = 0;
        after      = 0;
        for (int n = 1; n <= 60 && after < 3; n++) begin
            run_step(one0);
            if (n == 1) check("step1_v0", {96'd0, v_out[31:0]}, {96'd0, 32'h0000_2000});
            if (n == 2) begin
                check("step2_v0", {96'd0, v_out[31:0]}, {96'd0, 32'h0000_3C00});
                check("step2_lanes123", {32'd0, v_out[127:32]}, '0);
            end
            if (first_seen != 0) begin
                after++;
                if (after < 3) begin
                    check("refrac_v0", {96'd0, v_out[31:0]}, '0);
                    check("refrac_spike0", {127'd0, spike[0]}, '0);
                end else begin
                    check("post_refrac_v0", {96'd0, v_out[31:0]}, {96'd0, 32'h0000_2000});
                end
            end else if (spike[0]) begin
                first_seen = n;
                check("first_spike_step", 128'(first_seen), 128'(first_pred));
                check("spike_v0", {96'd0, v_out[31:0]}, '0);
            end
        end
        check("spike_seen", {127'd0, first_seen != 0}, {127'd0, 1'b1});

        // Reset held for three cycles in the middle of a step.
        issue_step(rand_cur());
        repeat (5) @(negedge clk);
        rst = 1'b1;
        flush_sb();
        model_reset();
        repeat (3) @(negedge clk);
        check("midrst_v_out", v_out, '0);
        check("midrst_spike", {124'd0, spike}, '0);
        check("midrst_out_valid", {127'd0, out_valid}, '0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ready", {127'd0, step_ready}, {127'd0, 1'b1});

        // Extreme currents from rest.
        run_step({32'd0, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0});
        check("ext_v1", {96'd0, v_out[63:32]}, {96'd0, 32'hF000_0000});
        check("ext_spike2", {127'd0, spike[2]}, {127'd0, 1'b1});
        check("ext_v2", {96'd0, v_out[95:64]}, '0);

        // step_valid held high while i_in changes every cycle.
        acc = 0; low = 0; last_acc = 0; guard = 0;
        while (acc < 3 && guard < 200) begin
            @(negedge clk);
            guard++;
            i_in       = rand_cur();
            step_valid = 1'b1;
            if (step_ready) begin
                if (acc > 0) begin
                    check("ready_low_cycles", 128'(low), 128'd13);
                    check("accept_spacing", 128'(cyc - last_acc), 128'd14);
                end
                sb.push_back(model_step(i_in));
                n_push++;
                last_acc = cyc;
                acc++;
                low = 0;
            end else begin
                low++;
            end
        end
        check("handshake_accepts", 128'(acc), 128'd3);
        @(negedge clk);
        step_valid = 1'b0;
        wait_done();

        for (int n = 0; n < 20; n++) run_step(rand_cur());

        // Abort during INTEG of neuron 2, then a fresh step from rest.
        issue_step(rand_cur());
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        flush_sb();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_v_out", v_out, '0);
        check("abort_spike", {124'd0, spike}, '0);
        repeat (40) @(negedge clk);
        run_step(one0);
        check("abort_next_v0", {96'd0, v_out[31:0]}, {96'd0, 32'h0000_2000});

        repeat (3) @(negedge clk);
        check("sb_drained", 128'(sb.size()), '0);
        check("pulse_count", 128'(n_pop), 128'(n_push));
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
